c_bram_reader: RTL and testbench

Drains the finished result matrix C out of the C BRAM after the matrix-multiply controller signals completion. It reads all M*N 32-bit float results through the C BRAM read port and presents them on a valid/ready stream with last-beat marking. It sits on the opposite side of the C BRAM from the controller, which is its only writer: the controller writes results, this block reads them out to the host or downstream logic.

---
 rtl/matmul_pkg.sv | 20 ++
 rtl/c_bram_reader_fifo.sv | 61 ++++++
 rtl/c_bram_reader.sv | 142 ++++++++++++++
 tb/tb_c_bram_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply result path: widths, reader FSM states.
// Latency: none (package only).
// Backpressure: n/a.
package matmul_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    // Address width for a memory of 'depth' words; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_READ  = 2'd1,
        RD_DRAIN = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/c_bram_reader_fifo.sv
// result_fifo2: two-entry skid FIFO holding {index, data} beats returned from the C BRAM.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push on full is accepted only together with a pop; caller must respect credits.
module result_fifo2 #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push;
    logic         do_pop;

    assign full     = (cnt_q == 2'd2);
    assign empty    = (cnt_q == 2'd0);
    assign head_dat = rd_ptr_q ? mem1_q : mem0_q;

    // Next-state for storage, pointers and occupancy; push-on-full is legal when a pop frees a slot.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        if (do_push) begin
            if (wr_ptr_q) mem1_d = push_dat;
            else          mem0_d = push_dat;
        end
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/c_bram_reader.sv
// Drains the M*N result matrix from the C BRAM onto a valid/ready stream with m_last/m_idx.
// Latency: start at edge T -> first read in T+1, first m_valid in T+3, done pulse after last beat.
// Backpressure: at most 2 reads in flight + buffered; read enable drops the cycle m_ready falls.
// Build option: define C_READER_TRANSPOSE_EN for column-major issue order (m_idx still r*N+c).
module c_bram_reader
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int M          = 3,
    parameter int N          = 3,
    parameter int ADDR_W     = addr_w(M * N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  en_c_bram_out,
    output logic [ADDR_W-1:0]     addr_c_bram_out,
    input  logic [DATA_WIDTH-1:0] c_bram_rdata,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [ADDR_W-1:0]     m_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int MN = M * N;
    localparam int FW = DATA_WIDTH + ADDR_W;

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_idx_q, pend_idx_d;

    logic [ADDR_W-1:0] cur_addr;
    logic [2:0]        used;
    logic              issue;
    logic              last_issue;
    logic              pop;
    logic [FW-1:0]     head_dat;
    logic [ADDR_W-1:0] head_idx;
    logic              fifo_full;
    logic              fifo_empty;

    result_fifo2 #(.W(FW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pend_q),
        .push_dat ({pend_idx_q, c_bram_rdata}),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign head_idx        = head_dat[FW-1 -: ADDR_W];
    assign m_valid         = !fifo_empty;
    assign m_data          = m_valid ? head_dat[DATA_WIDTH-1:0] : '0;
    assign m_idx           = m_valid ? head_idx : '0;
    assign m_last          = m_valid && (head_idx == ADDR_W'(MN - 1));
    assign pop             = m_valid && m_ready;
    assign busy            = (state_q != RD_IDLE);
    assign done            = (state_q == RD_DONE);
    assign en_c_bram_out   = issue;
    assign addr_c_bram_out = cur_addr;

    // Read issue: credit check counts the beat leaving this cycle so full-rate streaming has no bubble.
    always_comb begin
        cur_addr   = ADDR_W'(row_q * N + col_q);
        used       = (fifo_full ? 3'd2 : {2'b00, !fifo_empty}) + {2'b00, pend_q};
        issue      = (state_q == RD_READ) && (used < (pop ? 3'd3 : 3'd2));
        last_issue = issue && (row_q == ADDR_W'(M - 1)) && (col_q == ADDR_W'(N - 1));
    end

    // FSM and row/column walk; counters return to 0 after the final issue so the address idles at 0.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        pend_d     = issue;
        pend_idx_d = issue ? cur_addr : pend_idx_q;
        case (state_q)
            RD_IDLE: begin
                if (start) begin
                    state_d = RD_READ;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RD_READ: begin
                if (last_issue) begin
                    state_d = RD_DRAIN;
                    row_d   = '0;
                    col_d   = '0;
                end else if (issue) begin
`ifdef C_READER_TRANSPOSE_EN
                    if (row_q == ADDR_W'(M - 1)) begin
                        row_d = '0;
                        col_d = col_q + 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
`else
                    if (col_q == ADDR_W'(N - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
`endif
                end
            end
            RD_DRAIN: begin
                if (pop && m_last) state_d = RD_DONE;
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // State registers; reset drops any read in flight so its data is never pushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RD_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
        end
    end

endmodule

// File: tb/tb_c_bram_reader.sv
// Directed bench for c_bram_reader: full-rate drain, stall/resume, random ready, held start, mid-drain reset.
// Expected order follows C_READER_TRANSPOSE_EN when the bench is built with it.
module tb_c_bram_reader;

    localparam int DW = 32;
    localparam int M  = 3;
    localparam int N  = 3;
    localparam int MN = 9;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          en_c_bram_out;
    logic [AW-1:0] addr_c_bram_out;
    logic [DW-1:0] c_bram_rdata;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [AW-1:0] m_idx;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;
    int issued = 0;
    int accepted = 0;
    int max_out = 0;

    logic [DW-1:0] mem [MN];

    c_bram_reader #(.DATA_WIDTH(DW), .M(M), .N(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .en_c_bram_out   (en_c_bram_out),
        .addr_c_bram_out (addr_c_bram_out),
        .c_bram_rdata    (c_bram_rdata),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_last          (m_last),
        .m_idx           (m_idx),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // One-cycle-latency BRAM read port.
    always @(posedge clk) begin
        if (en_c_bram_out) c_bram_rdata <= mem[addr_c_bram_out];
    end

    // Track reads issued minus beats accepted (in flight + buffered).
    always @(posedge clk) begin
        if (rst) begin
            issued   = 0;
            accepted = 0;
        end else begin
            if (en_c_bram_out) issued++;
            if (m_valid && m_ready) accepted++;
            if (issued - accepted > max_out) max_out = issued - accepted;
        end
    end

    function automatic int exp_idx(input int k);
`ifdef C_READER_TRANSPOSE_EN
        return (k % M) * N + (k / M);
`else
        return k;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".en"},    64'(en_c_bram_out),   64'd0);
        check({tag, ".addr"},  64'(addr_c_bram_out), 64'd0);
        check({tag, ".valid"}, 64'(m_valid),         64'd0);
        check({tag, ".data"},  64'(m_data),          64'd0);
        check({tag, ".idx"},   64'(m_idx),           64'd0);
        check({tag, ".last"},  64'(m_last),          64'd0);
        check({tag, ".busy"},  64'(busy),            64'd0);
        check({tag, ".done"},  64'(done),            64'd0);
    endtask

    // Start pulse with m_ready high: cycle-exact check of the whole drain.
    task automatic run_full_drain(input string tag);
        int e;
        m_ready = 1'b1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        check({tag, ".t1_en"},    64'(en_c_bram_out),   64'd1);
        check({tag, ".t1_addr"},  64'(addr_c_bram_out), 64'(exp_idx(0)));
        check({tag, ".t1_busy"},  64'(busy),            64'd1);
        check({tag, ".t1_valid"}, 64'(m_valid),         64'd0);
        step();
        check({tag, ".t2_valid"}, 64'(m_valid),         64'd0);
        check({tag, ".t2_addr"},  64'(addr_c_bram_out), 64'(exp_idx(1)));
        step();
        for (int k = 0; k < MN; k++) begin
            e = exp_idx(k);
            check($sformatf("%s.beat%0d_valid", tag, k), 64'(m_valid), 64'd1);
            check($sformatf("%s.beat%0d_idx", tag, k),   64'(m_idx),   64'(e));
            check($sformatf("%s.beat%0d_data", tag, k),  64'(m_data),  64'(32'h3F80_0000 + e));
            check($sformatf("%s.beat%0d_last", tag, k),  64'(m_last),  64'(k == MN - 1));
            check($sformatf("%s.beat%0d_done", tag, k),  64'(done),    64'd0);
            step();
        end
        check({tag, ".done_pulse"}, 64'(done),    64'd1);
        check({tag, ".done_valid"}, 64'(m_valid), 64'd0);
        check({tag, ".done_busy"},  64'(busy),    64'd1);
        step();
        check({tag, ".after_done"}, 64'(done), 64'd0);
        check({tag, ".after_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int got;
        int e;
        int a0;
        logic seen;
        logic [DW-1:0] held_data;
        logic [AW-1:0] held_idx;

        for (int i = 0; i < MN; i++) mem[i] = 32'h3F80_0000 + i;
        rst = 1'b1; start = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Full-rate drain.
        run_full_drain("stream");

        // Stall for 10 cycles after the first beat, then resume.
        m_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("stall.beat0_idx", 64'(m_idx), 64'(exp_idx(0)));
        step();
        m_ready   = 1'b0;
        held_data = m_data;
        held_idx  = m_idx;
        check("stall.held_idx", 64'(held_idx), 64'(exp_idx(1)));
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("stall.c%0d_en", i),    64'(en_c_bram_out), 64'd0);
            check($sformatf("stall.c%0d_valid", i), 64'(m_valid),       64'd1);
            check($sformatf("stall.c%0d_idx", i),   64'(m_idx),         64'(held_idx));
            check($sformatf("stall.c%0d_data", i),  64'(m_data),        64'(held_data));
        end
        m_ready = 1'b1;
        for (int k = 1; k < MN; k++) begin
            e = exp_idx(k);
            check($sformatf("resume.beat%0d_valid", k), 64'(m_valid), 64'd1);
            check($sformatf("resume.beat%0d_idx", k),   64'(m_idx),   64'(e));
            check($sformatf("resume.beat%0d_data", k),  64'(m_data),  64'(32'h3F80_0000 + e));
            step();
        end
        check("resume.done", 64'(done), 64'd1);
        step();

        // Random m_ready: order, no loss or duplication, bounded outstanding reads.
        start = 1'b1;
        step();
        start = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 300 && got < MN; cyc++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (m_valid && m_ready) begin
                e = exp_idx(got);
                check($sformatf("rand.beat%0d_idx", got),  64'(m_idx),  64'(e));
                check($sformatf("rand.beat%0d_data", got), 64'(m_data), 64'(32'h3F80_0000 + e));
                check($sformatf("rand.beat%0d_last", got), 64'(m_last), 64'(got == MN - 1));
                got++;
            end
            step();
        end
        check("rand.beat_count", 64'(got), 64'(MN));
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (done) seen = 1'b1;
            else step();
        end
        check("rand.done_seen", 64'(seen), 64'd1);
        check("rand.max_outstanding_le2", 64'(max_out <= 2), 64'd1);
        step();

        // Start held high: one drain, re-trigger only after passing through IDLE.
        m_ready = 1'b1;
        start   = 1'b1;
        a0      = accepted;
        seen    = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        check("held.done_seen", 64'(seen), 64'd1);
        check("held.beats", 64'(accepted - a0), 64'(MN));
        step();
        check("held.idle_busy", 64'(busy), 64'd0);
        step();
        check("held.retrigger_busy", 64'(busy), 64'd1);
        start = 1'b0;
        a0    = accepted;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        check("held.second_done", 64'(seen), 64'd1);
        check("held.second_beats", 64'(accepted - a0), 64'(MN));
        step();

        // Reset at beat 4, then a clean full drain.
        m_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("midrst.beat4_idx", 64'(m_idx), 64'(exp_idx(4)));
        rst = 1'b1;
        step();
        check_reset_outputs("midrst");
        rst = 1'b0;
        step();
        check("midrst.quiet1_valid", 64'(m_valid), 64'd0);
        step();
        check("midrst.quiet2_valid", 64'(m_valid), 64'd0);
        check("midrst.quiet2_busy",  64'(busy),    64'd0);
        run_full_drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
